// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read path: RAM read latency, skid depth and the level type.
package fifo_pkg;
  localparam int RD_LATENCY = 1;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] level_t;

  // Words buffered plus the word returning from the RAM this cycle.
  function automatic logic [2:0] occ_plus(input level_t occ, input logic inflight);
    return {1'b0, occ} + {2'b00, inflight};
  endfunction
endpackage

// File: rtl/stream_skid_buf.sv
// Output register plus one skid register. New words take the output slot when it is free or draining;
// otherwise they wait in the skid slot. Zero-bubble at 1 word/cycle; out_valid holds while out_ready=0.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output level_t                level
);

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  fire;

  assign fire = out_vld_q & out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (clear) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (fire) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = in_valid;
        if (in_valid) skid_dat_d = in_data;
      end else begin
        out_vld_d = in_valid;
        if (in_valid) out_dat_d = in_data;
      end
    end else if (in_valid) begin
      if (!out_vld_q) begin
        out_vld_d = 1'b1;
        out_dat_d = in_data;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign level     = {1'b0, out_vld_q} + {1'b0, skid_vld_q};

  // A word arriving with both slots full and nothing leaving would be lost.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(in_valid && skid_vld_q && !fire && !clear));
  a_skid_behind_out: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(skid_vld_q && !out_vld_q));

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the FIFO, absorbs the RAM read latency and presents words as a valid/ready stream.
// Pop-to-valid latency 2 cycles; pops only when the returning word is guaranteed a skid slot.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_empty,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_r_data,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_level
);

  logic   inflight_q, inflight_d;
  logic   fire;
  level_t occ;

  assign fire = o_valid & i_ready;

  // Space is counted including the word already on its way back from the RAM.
  assign o_rd = ~i_empty & ~i_clear &
                ((occ_plus(occ, inflight_q) < 3'(SKID_DEPTH)) | fire);

  assign inflight_d = o_rd;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (i_clear),
    .in_valid  (inflight_q),
    .in_data   (i_r_data),
    .out_valid (o_valid),
    .out_data  (o_data),
    .out_ready (i_ready),
    .level     (occ)
  );

  assign o_level = occ;

  a_level_legal: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    o_level != 2'd3);
  a_occ_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    occ_plus(occ, inflight_q) <= 3'(SKID_DEPTH));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed stimulus against a behavioural FIFO; a scoreboard queue is checked on every fire.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;

  logic          i_clk     = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          empty_q   = 1'b1;
  logic          i_empty;
  logic          o_rd;
  logic [DW-1:0] i_r_data  = '0;
  logic          i_clear   = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready   = 1'b0;
  logic [1:0]    o_level;

  logic [7:0] mem_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  // The shared reset holds the FIFO's empty flag high.
  assign i_empty = ~i_reset_n | empty_q;

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_empty   (i_empty),
    .o_rd      (o_rd),
    .i_r_data  (i_r_data),
    .i_clear   (i_clear),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_level   (o_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // FIFO model: RAM data appears the cycle after a pop.
  always @(posedge i_clk) begin
    if (o_rd && mem_q.size() != 0) i_r_data <= mem_q.pop_front();
    empty_q <= (mem_q.size() == 0);
  end

  // Scoreboard monitor, sampled mid-cycle.
  logic          prev_vld = 1'b0, prev_rdy = 1'b0, prev_clr = 1'b0, prev_rst = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  always @(negedge i_clk) begin
    if (o_rd && i_empty) chk("rd_while_empty", 32'(o_rd), 32'd0);
    if (i_reset_n && prev_rst && prev_vld && !prev_rdy && !prev_clr) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(prev_dat));
    end
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h required none at %0t", o_data, $time);
      end else begin
        chk("stream_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    prev_vld = o_valid;
    prev_rdy = i_ready;
    prev_clr = i_clear;
    prev_rst = i_reset_n;
    prev_dat = o_data;
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic load(input logic [7:0] base, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      mem_q.push_back(8'(base + 8'(i)));
      if (expect_out) exp_q.push_back(8'(base + 8'(i)));
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk({name, "_idle_vld"}, 32'(o_valid), 32'd0);
    chk({name, "_idle_lvl"}, 32'(o_level), 32'd0);
  endtask

  initial begin
    int rd_cnt;
    int k;

    // Reset state
    repeat (3) step();
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_lvl", 32'(o_level), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    i_reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("idle_rd", 32'(o_rd), 32'd0);
      chk("idle_vld", 32'(o_valid), 32'd0);
      chk("idle_lvl", 32'(o_level), 32'd0);
      step();
    end

    // Four words, consumer always ready: pops c0..c3, valid c2..c5
    i_ready = 1'b1;
    load(8'h10, 4, 1'b1);
    step();
    for (int c = 0; c < 8; c++) begin
      chk("burst_rd", 32'(o_rd), 32'(c < 4));
      chk("burst_vld", 32'(o_valid), 32'(c >= 2 && c <= 5));
      step();
    end
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // Six words, consumer stalled: two pops then a full, stable buffer
    i_ready = 1'b0;
    load(8'h20, 6, 1'b1);
    step();
    rd_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (c >= 4) begin
        chk("stall_lvl", 32'(o_level), 32'(SKID_DEPTH));
        chk("stall_rd", 32'(o_rd), 32'd0);
        chk("stall_vld", 32'(o_valid), 32'd1);
        chk("stall_data", 32'(o_data), 32'h20);
      end
      if (o_rd) rd_cnt++;
      step();
    end
    chk("stall_rd_pulses", 32'(rd_cnt), 32'd2);
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("stall_release_vld", 32'(o_valid), 32'd1);
      step();
    end
    chk("stall_release_end", 32'(o_valid), 32'd0);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Sixteen words under alternating ready
    load(8'h30, 16, 1'b1);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      i_ready = (k % 2 == 0);
      step();
      k++;
    end
    i_ready = 1'b1;
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("toggle_idle_vld", 32'(o_valid), 32'd0);

    // Flush with one word buffered and one returning: 41 and 42 are lost
    i_ready = 1'b0;
    load(8'h40, 6, 1'b0);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h45);
    step();
    repeat (5) step();
    chk("clr_pre_lvl", 32'(o_level), 32'd2);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    i_clear = 1'b1;
    #1;
    chk("clr_mid_lvl", 32'(o_level), 32'd1);
    chk("clr_mid_vld", 32'(o_valid), 32'd1);
    chk("clr_rd_forced", 32'(o_rd), 32'd0);
    step();
    i_clear = 1'b0;
    chk("clr_post_vld", 32'(o_valid), 32'd0);
    chk("clr_post_lvl", 32'(o_level), 32'd0);
    i_ready = 1'b1;
    drain("clr", 50);

    // Asynchronous reset mid-stream
    load(8'h50, 8, 1'b1);
    step();
    repeat (4) step();
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("arst_vld", 32'(o_valid), 32'd0);
    chk("arst_lvl", 32'(o_level), 32'd0);
    mem_q.delete();
    exp_q.delete();
    step();
    step();
    i_reset_n = 1'b1;
    step();
    load(8'h60, 4, 1'b1);
    drain("arst", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
